alu_mc: RTL and testbench

Parametrised multi-cycle ALU with registered result and flags and a valid/ready input handshake. It generalises the 4-bit combinational ALU to any operand width, makes barrel shifts take a variable amount, and adds an optional sequential shift-add multiplier. It sits between the operand/opcode source (control or testbench driver) and whatever consumes the result and NZCV flags.

---
 rtl/alu_mc.sv | 186 ++++++++++++++++++
 tb/tb_alu_mc.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_mc: multi-cycle ALU, WIDTH-bit operands, registered result and NZCV,    |
// | valid/ready input. `ALU_MUL_EN compiles in the sequential shift-add MUL.    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module alu_mc #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam int         MSB    = WIDTH - 1;

  logic [WIDTH-1:0] res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic             flag_n_q, flag_n_d, flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d, flag_v_q, flag_v_d;

  logic [WIDTH:0]   sum, diff, shl_ext, shr_ext;
  logic             shift_big;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  // The extra bit on each shift captures the last bit shifted out.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    shl_ext   = {1'b0, a} << b;
    shr_ext   = {a, 1'b0} >> b;
    shift_big = (b >= WIDTH'(WIDTH));
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = ~diff[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_SHR: begin
        alu_res = shift_big ? '0 : shr_ext[WIDTH:1];
        alu_c   = shift_big ? 1'b0 : shr_ext[0];
      end
      OP_SHL: begin
        alu_res = shift_big ? '0 : shl_ext[WIDTH-1:0];
        alu_c   = shift_big ? 1'b0 : shl_ext[WIDTH];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam int         CNT_W  = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign in_ready = (state_q == IDLE) && !rst;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign in_ready = !rst;
`endif

  always_comb begin
    res_d       = res_q;
    flag_n_d    = flag_n_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_v_d    = flag_v_q;
    out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (in_valid && in_ready && op == OP_MUL) begin
      // Bit 0 of b is folded into the accept edge so the product lands WIDTH cycles later.
      state_d  = MUL;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = b >> 1;
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      cnt_d    = CNT_W'(WIDTH - 1);
    end else
`endif
    if (in_valid && in_ready) begin
      res_d       = alu_res;
      flag_n_d    = alu_res[MSB];
      flag_z_d    = (alu_res == '0);
      flag_c_d    = alu_c;
      flag_v_d    = alu_v;
      out_valid_d = 1'b1;
    end
`ifdef ALU_MUL_EN
    if (state_q == MUL) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d     = IDLE;
        res_d       = acc_step[WIDTH-1:0];
        flag_n_d    = acc_step[MSB];
        flag_z_d    = (acc_step[WIDTH-1:0] == '0);
        flag_c_d    = (acc_step[2*WIDTH-1:WIDTH] != '0);
        flag_v_d    = (acc_step[2*WIDTH-1:WIDTH] != '0);
        out_valid_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      res_q       <= res_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign res       = res_q;
  assign out_valid = out_valid_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_alu_mc: directed vectors with hand-computed results for alu_mc, WIDTH=4. |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b;
  logic [2:0] op;
  logic       out_valid;
  logic [3:0] res;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic [3:0] nzcv;

  int n_checks = 0;
  int n_errors = 0;

  assign nzcv = {flag_n, flag_z, flag_c, flag_v};

  alu_mc #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .res(res),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single accept edge and checks the result cycle.
  task automatic alu_op(input string tag, input logic [2:0] o, input logic [3:0] x,
                        input logic [3:0] y, input logic [3:0] exp_res, input logic [3:0] exp_nzcv);
    op = o; a = x; b = y; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " res"}, res, exp_res);
    check({tag, " nzcv"}, nzcv, exp_nzcv);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) next_cycle();
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset res", res, 0);
    check("reset nzcv", nzcv, 0);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", in_ready, 1);

    alu_op("add 15+15", 3'd0, 4'd15, 4'd15, 4'd14, 4'b1010);
    alu_op("add 7+1",   3'd0, 4'd7,  4'd1,  4'd8,  4'b1001);
    alu_op("sub 8-15",  3'd1, 4'd8,  4'd15, 4'd9,  4'b1000);
    alu_op("sub 8-8",   3'd1, 4'd8,  4'd8,  4'd0,  4'b0110);
    alu_op("shl 12<<1", 3'd3, 4'd12, 4'd1,  4'd8,  4'b1010);
    alu_op("shl 6<<3",  3'd3, 4'd6,  4'd3,  4'd0,  4'b0110);
    alu_op("shl 9<<3",  3'd3, 4'd9,  4'd3,  4'd8,  4'b1000);
    alu_op("shr 5>>4",  3'd2, 4'd5,  4'd4,  4'd0,  4'b0100);
    alu_op("shr 5>>1",  3'd2, 4'd5,  4'd1,  4'd2,  4'b0010);
    alu_op("shr 5>>0",  3'd2, 4'd5,  4'd0,  4'd5,  4'b0000);
    alu_op("and 0&15",  3'd4, 4'd0,  4'd15, 4'd0,  4'b0100);

    next_cycle();
    check("idle out_valid", out_valid, 0);
    check("idle res held", res, 0);
    check("idle nzcv held", nzcv, 4'b0100);

    // Three accepts on consecutive edges.
    alu_op("b2b xor 7^3", 3'd6, 4'd7, 4'd3, 4'd4, 4'b0000);
    alu_op("b2b or 5|2",  3'd5, 4'd5, 4'd2, 4'd7, 4'b0000);
    alu_op("b2b and 3&1", 3'd4, 4'd3, 4'd1, 4'd1, 4'b0000);
    next_cycle();
    check("b2b end out_valid", out_valid, 0);
    check("b2b end res held", res, 1);

`ifdef ALU_MUL_EN
    op = 3'd7; a = 4'd5; b = 4'd3; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("mul 5*3 busy%0d in_ready", i), in_ready, 0);
      check($sformatf("mul 5*3 busy%0d out_valid", i), out_valid, 0);
      if (i < 3) next_cycle();
    end
    next_cycle();
    check("mul 5*3 out_valid", out_valid, 1);
    check("mul 5*3 in_ready", in_ready, 1);
    check("mul 5*3 res", res, 15);
    check("mul 5*3 nzcv", nzcv, 4'b1000);

    op = 3'd7; a = 4'd15; b = 4'd15; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    repeat (3) next_cycle();
    check("mul 15*15 out_valid", out_valid, 1);
    check("mul 15*15 res", res, 1);
    check("mul 15*15 nzcv", nzcv, 4'b0011);

    op = 3'd7; a = 4'd7; b = 4'd7; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    check("mul abort in_ready", in_ready, 0);
    check("mul abort out_valid", out_valid, 0);
    check("mul abort res", res, 0);
    check("mul abort nzcv", nzcv, 0);
    rst = 1'b0;
    #1;
    check("mul abort ready after rst", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      check($sformatf("mul abort quiet%0d", i), out_valid, 0);
    end
    check("mul abort res held", res, 0);
`else
    alu_op("op7 disabled 5,3", 3'd7, 4'd5, 4'd3, 4'd0, 4'b0100);
    check("op7 disabled in_ready", in_ready, 1);
    next_cycle();
    check("op7 disabled single pulse", out_valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
